// File: rtl/mux2a1_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter: FSM state
// encoding, requester identifiers (which double as the mux select value)
// and the width helper for the per-grant beat counter.
package mux2a1_arb_pkg;

  // Arbiter FSM states: nobody granted, or one of the two requesters owns the path
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  // Requester identity; the numeric value is exactly what drives the mux select
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Bits needed to hold a beat count from 0 up to max_beats inclusive
  function automatic int cnt_width(input int max_beats);
    if (max_beats < 1) begin
      return 1;
    end
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux2a1_arb_mux2a1.sv
// Single-bit 2:1 multiplexer; the arbiter builds its data path from one of
// these per data bit. sel=0 passes a, sel=1 passes b.
module mux2a1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  // Pure select, no state
  assign y = sel ? b : a;

endmodule

// File: rtl/mux2a1_arb.sv
// Round-robin arbiter sharing one 2:1 data path between requesters A and B.
// A grant lasts for one burst, ending on the requester's last flag, on the
// beat limit, or when the owner drops its request. The next owner is chosen
// in the same cycle the current burst ends, so bursts run back to back.
module mux2a1_arb
  import mux2a1_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_a,
  input  logic             last_b,
  output logic             ready_a,
  output logic             ready_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             sel,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  input  logic             ready_i
);

  localparam int CNT_W = cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  arb_state_e       state_q, state_d;
  req_id_e          prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;

  logic             win_valid;
  req_id_e          win_id;
  logic             granted_req;
  logic             granted_last;
  logic             xfer;
  logic             abort;
  logic             release_grant;
  logic             arbitrate;

  // Register all arbiter state; async reset drops any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= REQ_B;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Round-robin decision: a lone requester wins, on a tie the non-previous winner wins
  always_comb begin
    win_valid = 1'b0;
    win_id    = REQ_A;
    if (req_a && req_b) begin
      win_valid = 1'b1;
      win_id    = (prio_q == REQ_A) ? REQ_B : REQ_A;
    end else if (req_a) begin
      win_valid = 1'b1;
      win_id    = REQ_A;
    end else if (req_b) begin
      win_valid = 1'b1;
      win_id    = REQ_B;
    end
  end

  // Output decode: route valid/last/ready of the owner, flag the burst-ending beat
  always_comb begin
    grant_a      = (state_q == GNT_A);
    grant_b      = (state_q == GNT_B);
    granted_req  = (grant_a & req_a) | (grant_b & req_b);
    granted_last = (grant_a & last_a) | (grant_b & last_b);
    valid_o      = granted_req;
    last_o       = valid_o & (granted_last | (cnt_q == CNT_LIMIT));
    ready_a      = grant_a & ready_i;
    ready_b      = grant_b & ready_i;
    sel          = sel_q;
  end

  // Release conditions: a final beat accepted, or the owner abandoning its request
  always_comb begin
    xfer          = valid_o & ready_i;
    abort         = (state_q != IDLE) & ~granted_req;
    release_grant = (xfer & last_o) | abort;
    arbitrate     = (state_q == IDLE) | release_grant;
  end

  // Next-state: re-arbitrate from IDLE or on release, otherwise count accepted beats
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (arbitrate) begin
      if (win_valid) begin
        state_d = (win_id == REQ_A) ? GNT_A : GNT_B;
        prio_d  = win_id;
        cnt_d   = '0;
        sel_d   = win_id;
      end else begin
        state_d = IDLE;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // One mux bit per data bit, all steered by the registered select
  for (genvar i = 0; i < WIDTH; i++) begin : g_data_mux
    mux2a1 u_mux (
      .a   (data_a[i]),
      .b   (data_b[i]),
      .sel (sel_q),
      .y   (data_o[i])
    );
  end

endmodule

// File: tb/tb_mux2a1_arb.sv
// Bench for the round-robin arbiter: directed scenarios followed by random
// traffic, every cycle compared against a burst-level reference model.
module tb_mux2a1_arb;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;

  logic             clk;
  logic             rst_n;
  logic             req_a, req_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic             last_a, last_b;
  logic             ready_a, ready_b;
  logic             grant_a, grant_b;
  logic             sel;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the path (0 nobody, 1 A, 2 B), beats taken
  // this burst, the previous winner and the select value held between bursts
  int m_owner;
  int m_beats;
  int m_last_win;
  int m_sel;

  mux2a1_arb #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .last_a  (last_a),
    .last_b  (last_b),
    .ready_a (ready_a),
    .ready_b (ready_b),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .sel     (sel),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_beats    = 0;
    m_last_win = 2;
    m_sel      = 0;
  endtask

  // Expected outputs derived from the current owner and the inputs on the pins
  task automatic checkOutput();
    logic e_valid, e_last, own_last;
    e_valid  = (m_owner == 1) ? req_a : (m_owner == 2) ? req_b : 1'b0;
    own_last = (m_owner == 1) ? last_a : (m_owner == 2) ? last_b : 1'b0;
    e_last   = e_valid && (own_last || (m_beats == MAX_BEATS - 1));
    check1("grant_a", 32'(grant_a), 32'(m_owner == 1));
    check1("grant_b", 32'(grant_b), 32'(m_owner == 2));
    check1("sel",     32'(sel),     32'(m_sel));
    check1("valid_o", 32'(valid_o), 32'(e_valid));
    check1("last_o",  32'(last_o),  32'(e_last));
    check1("ready_a", 32'(ready_a), 32'((m_owner == 1) && ready_i));
    check1("ready_b", 32'(ready_b), 32'((m_owner == 2) && ready_i));
    check1("data_o",  32'(data_o),  32'((m_sel != 0) ? data_b : data_a));
    check1("cnt",     32'(dut.cnt_q), 32'(m_beats));
  endtask

  // Advance the model across one rising edge using the inputs that were sampled
  task automatic model_step();
    int winner;
    bit e_valid, own_last, e_last, xfer, rel;
    e_valid  = (m_owner == 1) ? req_a : (m_owner == 2) ? req_b : 1'b0;
    own_last = (m_owner == 1) ? last_a : (m_owner == 2) ? last_b : 1'b0;
    e_last   = e_valid && (own_last || (m_beats == MAX_BEATS - 1));
    xfer     = e_valid && ready_i;
    rel      = (xfer && e_last) || (m_owner != 0 && !e_valid);
    if (m_owner == 0 || rel) begin
      if (req_a && req_b) winner = (m_last_win == 1) ? 2 : 1;
      else if (req_a)     winner = 1;
      else if (req_b)     winner = 2;
      else                winner = 0;
      m_owner = winner;
      if (winner != 0) begin
        m_beats    = 0;
        m_last_win = winner;
        m_sel      = winner - 1;
      end
    end else if (xfer) begin
      m_beats++;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, cross the rising edge
  task automatic applyStimulus(input bit ra, input bit rb, input bit la, input bit lb,
                               input bit rdy);
    req_a   = ra;
    req_b   = rb;
    last_a  = la;
    last_b  = lb;
    ready_i = rdy;
    data_a  = WIDTH'($urandom);
    data_b  = WIDTH'($urandom);
    #1;
    checkOutput();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {req_a, req_b, last_a, last_b, ready_i} = '0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    data_a = '0;
    data_b = '0;
    model_reset();
    @(negedge clk);
    $display("[TB] reset state");
    do_reset();

    $display("[TB] lone A burst of 3 beats");
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] both requesting, bursts of 2");
    do_reset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, m_beats == 1, m_beats == 1, 1);
    end

    $display("[TB] forced release on beat limit");
    do_reset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1, 0, 0, 1);
    end

    $display("[TB] ready stall during A burst");
    do_reset();
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);

    $display("[TB] B aborts mid-burst, A takes over");
    do_reset();
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);

    $display("[TB] asynchronous reset mid-burst");
    do_reset();
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    req_b   = 1'b1;
    ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);

    $display("[TB] random traffic");
    do_reset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2a1_arb.md
# mux2a1_arb

Two-requester round-robin arbiter that shares one 2:1 select datapath between requesters A and B. It sits in front of the mux2a1 select path and owns the select line. It grants one requester at a time for a burst of beats and routes that requester's data, last flag and ready handshake to a single downstream consumer. Bursts end on `last` or on a beat-count limit, so neither requester can starve the other.

## Interface
Parameters:
- `WIDTH`, default 8: data width per requester and on the output.
- `MAX_BEATS`, default 16: maximum transfers per grant before forced release. Must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_a` / `req_b`, in, 1: requester wants the path. Doubles as per-beat valid while granted.
- `data_a` / `data_b`, in, WIDTH: requester data.
- `last_a` / `last_b`, in, 1: the current beat is the final beat of the burst.
- `ready_a` / `ready_b`, out, 1: `ready_i` routed to the granted requester. 0 for the other requester.
- `grant_a` / `grant_b`, out, 1: registered one-hot-or-zero grant.
- `sel`, out, 1: mux select. 0 selects A, 1 selects B.
- `data_o`, out, WIDTH: selected data. Equals `sel ? data_b : data_a`.
- `valid_o`, out, 1: a beat is offered downstream.
- `last_o`, out, 1: the offered beat ends the grant (natural or forced).
- `ready_i`, in, 1: downstream accepts the beat.

## Operation
- FSM states are `IDLE`, `GNT_A` and `GNT_B`. `grant_a` = (state==GNT_A). `grant_b` = (state==GNT_B).
- `prio` register holds the last winner. It resets to B, so A wins the first tie.
- **Decision function** (used from IDLE, and at grant release):
  - Only one requester asserting: grant it.
  - Both requesting: grant the one that is not `prio`.
  - Neither requesting: go to IDLE.
- `prio` updates to the winner whenever a grant is issued.
- **Transfer** occurs when `valid_o & ready_i`.
  - `valid_o` = (GNT_A & req_a) | (GNT_B & req_b).
  - `ready_a` = GNT_A & ready_i. `ready_b` = GNT_B & ready_i.
- **Beat counter** `cnt` has width clog2(MAX_BEATS+1). It clears on every new grant and increments on each transfer.
- `last_o` = `valid_o` & (granted `last_x` | `cnt`==MAX_BEATS-1).
- **Release** triggers on either of:
  - a transfer with `last_o`=1;
  - the granted requester dropping `req` while granted (abort). No transfer happens for that cycle.
- On release, the decision function runs in the same cycle. The next state is a new grant or IDLE, with no bubble cycle.
- After a forced release, a requester that is still requesting is treated as a fresh request and arbitrates normally.
- `sel` is registered. It updates with each new grant and holds its value in IDLE, so `data_o` does not glitch between bursts.
- `ready_i` low stalls the burst. Grant, `cnt` and `sel` all hold.

## Timing
- Reset values:
  - state=IDLE, `prio`=B, `cnt`=0, `sel`=0;
  - `grant_a`=`grant_b`=0;
  - `valid_o`=`last_o`=`ready_a`=`ready_b`=0;
  - `data_o`=`data_a` (because `sel`=0).
- Request-to-grant latency from IDLE: 1 cycle. A `req` sampled at edge N gives a grant visible after edge N.
- Release-to-new-grant: 0 bubble. The cycle after the final transfer already shows the new grant.
- `data_o`, `valid_o`, `last_o`, `ready_a`, `ready_b`: combinational from registered state and current inputs. No added latency.
- Simultaneous release and new request from the same requester, with the other requester idle: that requester is regranted immediately and `cnt` clears.
- `rst_n` asserted mid-burst: outputs go to reset values asynchronously. The burst is dropped and no transfer completes in that cycle.
- MAX_BEATS=1: every transfer carries `last_o`=1. With both requesting, grants strictly alternate.

## Structure
- Shared package:
  - FSM state enum (`IDLE`, `GNT_A`, `GNT_B`);
  - requester-ID encoding (A=0, B=1), identical to the `sel` encoding;
  - the clog2-based width helper for `cnt`.
- One sub-module is natural: instantiate `mux2a1` per data bit (generate loop) for `data_o`, driven by `sel`. Control logic stays in the top module.

## Test plan
- Reset, then `req_a`=1 alone with 3 beats and `last_a` on the 3rd, `ready_i`=1 → `grant_a` rises 1 cycle later; 3 transfers; `last_o` on beat 3; IDLE on the next cycle.
- `req_a`=`req_b`=1 from reset, bursts of 2 → grant order A, B, A, B; back-to-back with no idle cycle; `sel` toggles 0,1,0,1.
- MAX_BEATS=4, `req_a` held with `last_a`=0, `req_b`=1 → `last_o` forced on A's 4th beat; next cycle `grant_b`=1 and `cnt`=0.
- `ready_i` toggled 1,0,0,1 during an A burst → `data_o`=`data_a` is held; `cnt` advances only on ready cycles; `sel` remains stable.
- `req_b` dropped mid-burst while `req_a`=1 → next cycle `grant_a`=1; no transfer on the abort cycle.
- `rst_n` pulled low mid-burst (asynchronous, between edges) → `grant_*`, `valid_o` and `sel` go to 0 immediately; after release, A wins the first tie.
